// File: rtl/i2s_clk_pkg.sv
// Shared widths, reset ratios and state type for the I2S clock sequencer.
package i2s_clk_pkg;

  localparam int unsigned I2S_HALF_W    = 8;
  localparam int unsigned I2S_SLOT_W    = 6;
  localparam int unsigned I2S_DEF_HALF  = 2;
  localparam int unsigned I2S_DEF_SLOT  = 32;
  // Smallest legal ratio; a requested 0 is promoted to this.
  localparam int unsigned I2S_MIN_RATIO = 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } i2s_state_e;

endpackage

// File: rtl/i2s_div_cnt.sv
// Terminal-count counter: counts while enabled, wraps to 0 at i_term and flags o_tick.
module i2s_div_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_in,
  input  logic         ar,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_term);

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/i2s_clk_ctrl.sv
// I2S BCLK/LRCK sequencer with run-time ratios changed only on frame boundaries.
// Optional frame counter output enabled by defining I2S_FRAME_CNT_EN.
module i2s_clk_ctrl
  import i2s_clk_pkg::*;
#(
  parameter int unsigned HALF_W   = I2S_HALF_W,
  parameter int unsigned SLOT_W   = I2S_SLOT_W,
  parameter int unsigned DEF_HALF = I2S_DEF_HALF,
  parameter int unsigned DEF_SLOT = I2S_DEF_SLOT
) (
  input  logic              clk_in,
  input  logic              ar,
  input  logic              run_req,
  input  logic              cfg_valid,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic [SLOT_W-1:0] cfg_slot,
  output logic              cfg_ack,
  output logic              bclk,
  output logic              lrck,
  output logic              bclk_fall,
  output logic              frame_start,
  output logic              busy
`ifdef I2S_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  i2s_state_e        r_state, w_state_d;
  logic              r_bclk, r_lrck, r_bclk_fall, r_frame_start, r_cfg_ack, r_busy;
  logic              w_bclk_d, w_lrck_d, w_fall_d, w_fs_d, w_adopt;
  logic [HALF_W-1:0] r_half, w_cfg_half, w_hterm;
  logic [SLOT_W-1:0] r_slot, w_cfg_slot, w_sterm;
  logic              w_run, w_htick, w_btick, w_fall, w_bnd, w_adopt_ok;

  assign w_cfg_half = (cfg_half == '0) ? HALF_W'(I2S_MIN_RATIO) : cfg_half;
  assign w_cfg_slot = (cfg_slot == '0) ? SLOT_W'(I2S_MIN_RATIO) : cfg_slot;
  assign w_hterm    = r_half - HALF_W'(1);
  assign w_sterm    = r_slot - SLOT_W'(1);
  assign w_run      = (r_state != StIdle);
  assign w_fall     = w_htick & r_bclk;
  assign w_bnd      = w_btick & r_lrck;
  // Suppress a second ack while the producer is still seeing the first one.
  assign w_adopt_ok = cfg_valid & ~r_cfg_ack;

  i2s_div_cnt #(.W(HALF_W)) u_hcnt (
    .clk_in (clk_in),
    .ar     (ar),
    .i_clr  (~w_run),
    .i_en   (w_run),
    .i_term (w_hterm),
    .o_tick (w_htick)
  );

  i2s_div_cnt #(.W(SLOT_W)) u_bitcnt (
    .clk_in (clk_in),
    .ar     (ar),
    .i_clr  (~w_run),
    .i_en   (w_fall),
    .i_term (w_sterm),
    .o_tick (w_btick)
  );

  always_comb begin
    w_state_d = r_state;
    w_bclk_d  = r_bclk;
    w_lrck_d  = r_lrck;
    w_fall_d  = 1'b0;
    w_fs_d    = 1'b0;
    w_adopt   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_bclk_d = 1'b0;
        w_lrck_d = 1'b0;
        if (w_adopt_ok) begin
          w_adopt = 1'b1;
        end else if (run_req && !cfg_valid) begin
          w_state_d = StRun;
          w_fs_d    = 1'b1;
        end
      end
      StRun, StStop: begin
        if (w_htick) w_bclk_d = ~r_bclk;
        if (w_btick) w_lrck_d = ~r_lrck;
        w_fall_d = w_fall;
        if (run_req) begin
          w_state_d = StRun;
        end else if (r_state == StRun) begin
          w_state_d = StStop;
        end else if (w_bnd) begin
          w_state_d = StIdle;
        end
        if (w_bnd) begin
          w_adopt = w_adopt_ok;
          w_fs_d  = (w_state_d != StIdle);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      r_state       <= StIdle;
      r_bclk        <= 1'b0;
      r_lrck        <= 1'b0;
      r_bclk_fall   <= 1'b0;
      r_frame_start <= 1'b0;
      r_cfg_ack     <= 1'b0;
      r_busy        <= 1'b0;
      r_half        <= HALF_W'(DEF_HALF);
      r_slot        <= SLOT_W'(DEF_SLOT);
    end else begin
      r_state       <= w_state_d;
      r_bclk        <= w_bclk_d;
      r_lrck        <= w_lrck_d;
      r_bclk_fall   <= w_fall_d;
      r_frame_start <= w_fs_d;
      r_cfg_ack     <= w_adopt;
      r_busy        <= (w_state_d != StIdle);
      if (w_adopt) begin
        r_half <= w_cfg_half;
        r_slot <= w_cfg_slot;
      end
    end
  end

  assign bclk        = r_bclk;
  assign lrck        = r_lrck;
  assign bclk_fall   = r_bclk_fall;
  assign frame_start = r_frame_start;
  assign cfg_ack     = r_cfg_ack;
  assign busy        = r_busy;

`ifdef I2S_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      r_frame_cnt <= '0;
    end else if (r_state == StIdle && w_state_d == StRun) begin
      r_frame_cnt <= '0;
    end else if (r_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Scoreboard bench for i2s_clk_ctrl: a frame-phase arithmetic model predicts every output cycle.
module tb_i2s_clk_ctrl;

  logic       clk_in = 1'b0;
  logic       ar = 1'b0;
  logic       run_req = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_half = '0;
  logic [5:0] cfg_slot = '0;
  logic       cfg_ack, bclk, lrck, bclk_fall, frame_start, busy;

  i2s_clk_ctrl dut (
    .clk_in      (clk_in),
    .ar          (ar),
    .run_req     (run_req),
    .cfg_valid   (cfg_valid),
    .cfg_half    (cfg_half),
    .cfg_slot    (cfg_slot),
    .cfg_ack     (cfg_ack),
    .bclk        (bclk),
    .lrck        (lrck),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         tag;
    logic [5:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [5:0] got;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle / 1 run / 2 stop, t = cycles since the current frame began.
  int m_mode, m_t, m_h, m_s;
  bit m_ack, m_entry, m_ifall;
  bit pend;
  int p_h, p_s;

  function automatic void m_reset();
    m_mode = 0; m_t = 0; m_h = 2; m_s = 32;
    m_ack = 0; m_entry = 0; m_ifall = 0;
  endfunction

  // Output order: bclk, lrck, bclk_fall, frame_start, cfg_ack, busy
  function automatic logic [5:0] m_out();
    logic b, l, f, fs, bz;
    if (m_mode == 0) begin
      b = 0; l = 0; f = m_ifall; fs = 0; bz = 0;
    end else begin
      b  = ((m_t / m_h) % 2) == 1;
      l  = m_t >= 2 * m_h * m_s;
      f  = ((m_t % (2 * m_h)) == 0) && !m_entry;
      fs = (m_t == 0);
      bz = 1;
    end
    return {b, l, f, fs, m_ack, bz};
  endfunction

  function automatic void m_step(input bit run, input bit cv, input int ch, input int cs);
    bit ackn = 0;
    int ah = (ch == 0) ? 1 : ch;
    int as = (cs == 0) ? 1 : cs;
    m_ifall = 0;
    if (m_mode == 0) begin
      if (cv && !m_ack) begin
        m_h = ah; m_s = as; ackn = 1;
      end else if (run && !cv) begin
        m_mode = 1; m_t = 0; m_entry = 1;
      end
    end else begin
      bit bnd = (m_t + 1 == 4 * m_h * m_s);
      int nm = m_mode;
      if (run) nm = 1;
      else if (m_mode == 1) nm = 2;
      else if (bnd) nm = 0;
      m_entry = 0;
      if (bnd) begin
        if (cv && !m_ack) begin
          m_h = ah; m_s = as; ackn = 1;
        end
        m_t = 0;
        if (nm == 0) m_ifall = 1;
      end else begin
        m_t++;
      end
      m_mode = nm;
    end
    m_ack = ackn;
  endfunction

  task automatic cyc_step(input bit run);
    if (m_ack) pend = 1'b0;
    run_req   = run;
    cfg_valid = pend;
    cfg_half  = 8'(p_h);
    cfg_slot  = 6'(p_s);
    m_step(run, pend, p_h, p_s);
    sb.push_back('{tag: cyc + 1, v: m_out()});
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_n(input bit run, input int n);
    for (int i = 0; i < n; i++) cyc_step(run);
  endtask

  task automatic offer(input int h, input int s);
    pend = 1'b1; p_h = h; p_s = s;
  endtask

  task automatic wait_ack(input bit run);
    for (int i = 0; i < 2000 && pend; i++) cyc_step(run);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && m_mode != 0; i++) cyc_step(1'b0);
  endtask

  task automatic check_zero(input string name);
    got = {bclk, lrck, bclk_fall, frame_start, cfg_ack, busy};
    checks++;
    if (got !== 6'b0) begin
      failures++;
      $display("FAIL %s got=%b want=000000", name, got);
    end
  endtask

  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      got = {bclk, lrck, bclk_fall, frame_start, cfg_ack, busy};
      checks++;
      if (e.tag != cyc || got !== e.v) begin
        failures++;
        $display("FAIL outputs cyc=%0d tag=%0d got(bclk,lrck,fall,fs,ack,busy)=%b want=%b",
                 cyc, e.tag, got, e.v);
      end
    end
  end

  initial begin
    m_reset();
    pend = 0; p_h = 0; p_s = 0;
    #1 check_zero("reset_defaults");
    @(posedge clk_in);
    #3 ar = 1'b1;

    // Default ratios: 256-cycle frames.
    run_n(1'b1, 600);
    wait_idle();

    // 2/4 offered in IDLE, then run.
    offer(2, 4);
    wait_ack(1'b0);
    run_n(1'b1, 100);

    // 3/8 offered mid-frame, held until the boundary.
    offer(3, 8);
    wait_ack(1'b1);
    run_n(1'b1, 250);

    // Back to 2/4, then drop run_req mid-frame.
    offer(2, 4);
    wait_ack(1'b1);
    run_n(1'b1, 45);
    wait_idle();
    run_n(1'b0, 20);

    // Async reset in the middle of a run.
    offer(3, 5);
    wait_ack(1'b0);
    run_n(1'b1, 77);
    #2 ar = 1'b0;
    sb.delete();
    #1 check_zero("async_reset");
    run_req = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 check_zero("reset_hold");
    #2 ar = 1'b1;
    m_reset();
    run_n(1'b1, 300);
    wait_idle();

    // Zero ratios clamp to 1/1: 4-cycle frames.
    offer(0, 0);
    wait_ack(1'b0);
    run_n(1'b1, 40);
    wait_idle();

    // Randomised run/stop toggles and config offers.
    for (int p = 0; p < 30; p++) begin
      bit r;
      if (!pend && !m_ack && $urandom_range(0, 2) == 0)
        offer(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
      r = ($urandom_range(0, 3) != 0);
      run_n(r, int'($urandom_range(5, 80)));
    end
    wait_ack(1'b1);
    wait_idle();
    run_n(1'b0, 10);

    @(negedge clk_in);
    @(negedge clk_in);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
